// File: rtl/uln_seq.sv
// Registered logic/arithmetic unit with multi-cycle shifts and a start/busy/done handshake.
// Single-cycle ops complete on the accepting edge; shifts move one bit per cycle.
module uln_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       S,
  output logic [WIDTH-1:0] Out,
  output logic             zero,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] W_EXT = (WIDTH + 1)'(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] out_q;
  logic [CW-1:0]    cnt_q;
  logic             dir_right_q;
  logic             zero_q;
  logic             carry_q;
  logic             done_q;

  logic [CW-1:0]    n_d;
  logic             is_shift_d;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   diff_d;
  logic [WIDTH-1:0] work_next_d;
  logic             shout_d;

  // Shift count saturates at WIDTH: anything larger empties the register anyway.
  always_comb begin
    n_d        = ({1'b0, B} >= W_EXT) ? CW'(WIDTH) : CW'(B);
    is_shift_d = S[2] & S[1];
  end

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    res_d   = A;
    carry_d = 1'b0;
    sum_d   = {1'b0, A} + {1'b0, B};
    diff_d  = {1'b0, A} - {1'b0, B};
    case (S)
      3'b000:  res_d = A & B;
      3'b001:  res_d = A | B;
      3'b010:  res_d = A ^ B;
      3'b011:  res_d = ~A;
      3'b100: begin
        res_d   = sum_d[WIDTH-1:0];
        carry_d = sum_d[WIDTH];
      end
      3'b101: begin
        res_d   = diff_d[WIDTH-1:0];
        carry_d = diff_d[WIDTH];
      end
      default: res_d = A;
    endcase
  end

  always_comb begin
    work_next_d = dir_right_q ? (work_q >> 1) : (work_q << 1);
    shout_d     = dir_right_q ? work_q[0] : work_q[WIDTH-1];
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      // NOTE: work_q and dir_right_q are left unreset; they are always loaded before SHIFT reads them.
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_shift_d && (n_d != '0)) begin
              work_q      <= A;
              cnt_q       <= n_d;
              dir_right_q <= S[0];
              state_q     <= SHIFT;
            end else begin
              out_q   <= res_d;
              zero_q  <= (res_d == '0);
              carry_q <= carry_d;
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work_q <= work_next_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            out_q   <= work_next_d;
            zero_q  <= (work_next_d == '0);
            carry_q <= shout_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Out   = out_q;
  assign zero  = zero_q;
  assign carry = carry_q;
  assign busy  = (state_q == SHIFT);
  assign done  = done_q;

endmodule

// File: tb/tb_uln_seq.sv
// Self-checking bench for uln_seq (WIDTH=4): directed scenarios then randomized traffic,
// compared every cycle against a transaction-level model with a completion timer.
module tb_uln_seq;

  localparam int W    = 4;
  localparam int MOD  = 1 << W;
  localparam int MASK = MOD - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   S;
  logic [W-1:0] Out;
  logic         zero;
  logic         carry;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  uln_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .S     (S),
    .Out   (Out),
    .zero  (zero),
    .carry (carry),
    .busy  (busy),
    .done  (done)
  );

  int n_checks = 0;
  int n_bad    = 0;

  // Model: visible results plus a countdown to the pending completion.
  int m_out, m_zero, m_carry, m_done;
  int m_rem;
  int p_out, p_carry;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic void ref_op(input int a, input int b, input int s,
                                 output int r, output int c, output int lat);
    int n;
    n   = (b > W) ? W : b;
    c   = 0;
    lat = 1;
    case (s)
      0: r = a & b;
      1: r = a | b;
      2: r = a ^ b;
      3: r = (~a) & MASK;
      4: begin r = (a + b) % MOD; c = ((a + b) >= MOD) ? 1 : 0; end
      5: begin r = (a - b + MOD) % MOD; c = (a < b) ? 1 : 0; end
      6: begin
        r = (a << n) & MASK;
        if (n > 0) begin c = (a >> (W - n)) & 1; lat = n; end
      end
      default: begin
        r = a >> n;
        if (n > 0) begin c = (a >> (n - 1)) & 1; lat = n; end
      end
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic st, input int a, input int b, input int s);
    int res, c, lat;
    if (r) begin
      m_out = 0; m_zero = 0; m_carry = 0; m_done = 0; m_rem = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_out = p_out; m_carry = p_carry; m_zero = (p_out == 0); m_done = 1;
        end
      end else if (st) begin
        ref_op(a, b, s, res, c, lat);
        if (s >= 6 && lat > 1 || s >= 6 && b != 0) begin
          p_out = res; p_carry = c; m_rem = lat;
        end else begin
          m_out = res; m_carry = c; m_zero = (res == 0); m_done = 1;
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic st, input int a, input int b, input int s);
    reset = r;
    start = st;
    A     = a[W-1:0];
    B     = b[W-1:0];
    S     = s[2:0];
    @(posedge clk);
    model_edge(r, st, a & MASK, b & MASK, s & 7);
    #1;
    check("out",   32'(Out),   32'(m_out));
    check("zero",  32'(zero),  32'(m_zero));
    check("carry", 32'(carry), 32'(m_carry));
    check("busy",  32'(busy),  32'(m_rem > 0));
    check("done",  32'(done),  32'(m_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, 7));
  endtask

  initial begin
    m_out = 0; m_zero = 0; m_carry = 0; m_done = 0; m_rem = 0; p_out = 0; p_carry = 0;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; S = '0;

    cycle(1'b1, 1'b1, 4'b1111, 4'b1111, 4);
    cycle(1'b1, 1'b0, 0, 0, 0);
    idle(5);

    cycle(1'b0, 1'b1, 4'b1010, 4'b1100, 0);
    cycle(1'b0, 1'b1, 4'b1010, 4'b1100, 1);
    cycle(1'b0, 1'b1, 4'b1010, 4'b1100, 2);
    cycle(1'b0, 1'b1, 4'b1010, 4'b1100, 3);
    idle(1);

    cycle(1'b0, 1'b1, 4'b1111, 4'b0001, 4);
    cycle(1'b0, 1'b1, 4'b0011, 4'b0101, 5);
    cycle(1'b0, 1'b1, 4'b0101, 4'b0101, 5);
    idle(1);

    cycle(1'b0, 1'b1, 4'b0011, 2, 6);
    idle(3);
    cycle(1'b0, 1'b1, 4'b1011, 1, 7);
    idle(2);
    cycle(1'b0, 1'b1, 4'b0011, 4'b0111, 6);
    idle(5);
    cycle(1'b0, 1'b1, 4'b1001, 0, 7);
    idle(1);

    cycle(1'b0, 1'b1, 4'b0001, 3, 6);
    cycle(1'b0, 1'b1, 4'b1111, 4'b1111, 0);
    cycle(1'b0, 1'b1, 4'b1111, 4'b1111, 0);
    idle(3);

    cycle(1'b0, 1'b1, 4'b0110, 2, 7);
    idle(2);
    cycle(1'b0, 1'b1, 4'b1100, 4'b0101, 0);
    idle(1);

    cycle(1'b0, 1'b1, 4'b1111, 4, 7);
    cycle(1'b0, 1'b0, 0, 0, 0);
    cycle(1'b1, 1'b1, 4'b0001, 4'b0001, 0);
    idle(6);
    cycle(1'b0, 1'b1, 4'b0111, 4'b1101, 0);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      int s, b;
      s = $urandom_range(0, 7);
      b = (s >= 6) ? $urandom_range(0, 6) : $urandom_range(0, MASK);
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), $urandom_range(0, MASK), b, s);
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
